// File: rtl/cic_up96_stereo_sched_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cic_up96_stereo_sched_if : source, CIC Avalon-ST and destination signal bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface cic_up96_stereo_sched_if #(
  parameter int DATA_W = 16
);
  logic              src_strobe;
  logic [DATA_W-1:0] src_l;
  logic [DATA_W-1:0] src_r;
  logic              cic_in_valid;
  logic              cic_in_ready;
  logic [DATA_W-1:0] cic_in_data;
  logic              cic_in_sop;
  logic              cic_in_eop;
  logic [1:0]        cic_in_error;
  logic              cic_out_valid;
  logic              cic_out_ready;
  logic [DATA_W-1:0] cic_out_data;
  logic              cic_out_channel;
  logic [1:0]        cic_out_error;
  logic              dst_valid;
  logic              dst_ready;
  logic [DATA_W-1:0] dst_l;
  logic [DATA_W-1:0] dst_r;
  logic              overrun;
  logic              ch_err;
  logic              cic_err;
  logic              clr_flags;

  modport slave (
    input  src_strobe, src_l, src_r,
    output cic_in_valid, cic_in_data, cic_in_sop, cic_in_eop, cic_in_error,
    input  cic_in_ready,
    input  cic_out_valid, cic_out_data, cic_out_channel, cic_out_error,
    output cic_out_ready,
    output dst_valid, dst_l, dst_r,
    input  dst_ready,
    output overrun, ch_err, cic_err,
    input  clr_flags
  );

  modport master (
    output src_strobe, src_l, src_r,
    input  cic_in_valid, cic_in_data, cic_in_sop, cic_in_eop, cic_in_error,
    output cic_in_ready,
    output cic_out_valid, cic_out_data, cic_out_channel, cic_out_error,
    input  cic_out_ready,
    input  dst_valid, dst_l, dst_r,
    output dst_ready,
    input  overrun, ch_err, cic_err,
    output clr_flags
  );
endinterface
`default_nettype wire

// File: rtl/cic_up96_stereo_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cic_up96_stereo_sched : stereo pair packetiser / de-interleaver around a CIC
// Rev 1.0
// ---------------------------------------------------------------------------
module cic_up96_stereo_sched #(
  parameter int DATA_W     = 16,
  parameter int PEND_DEPTH = 2
) (
  input wire clk,
  input wire reset_n,
  cic_up96_stereo_sched_if.slave bus
);
  localparam int PW = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEND_L = 2'd1;
  localparam logic [1:0] S_SEND_R = 2'd2;

  logic [DATA_W-1:0] r_mem_l [PEND_DEPTH];
  logic [DATA_W-1:0] r_mem_r [PEND_DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count;
  logic [1:0]        r_state, w_state_nxt;

  logic              w_full, w_empty, w_wr, w_pop;
  logic [CW-1:0]     w_count_nxt;
  logic              w_in_valid, w_in_sop, w_in_eop;
  logic [DATA_W-1:0] w_in_data;

  logic              r_lpres, r_dst_valid;
  logic [DATA_W-1:0] r_lhold, r_dst_l, r_dst_r;
  logic              r_overrun, r_ch_err, r_cic_err;
  logic              w_out_ready, w_take, w_take_l, w_load;
  logic              w_set_ch, w_set_ce, w_set_ov;

  assign w_full      = (r_count == CW'(PEND_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_wr        = bus.src_strobe & ~w_full;
  assign w_pop       = (r_state == S_SEND_R) & bus.cic_in_ready;
  assign w_count_nxt = r_count + CW'(w_wr) - CW'(w_pop);

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PEND_DEPTH; i++) begin
        r_mem_l[i] <= '0;
        r_mem_r[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem_l[r_wptr] <= bus.src_l;
        r_mem_r[r_wptr] <= bus.src_r;
        r_wptr          <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!w_empty) w_state_nxt = S_SEND_L;
      S_SEND_L: if (bus.cic_in_ready) w_state_nxt = S_SEND_R;
      S_SEND_R: if (bus.cic_in_ready) w_state_nxt = (w_count_nxt != '0) ? S_SEND_L : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_valid = 1'b0;
    w_in_sop   = 1'b0;
    w_in_eop   = 1'b0;
    w_in_data  = '0;
    case (r_state)
      S_SEND_L: begin
        w_in_valid = 1'b1;
        w_in_sop   = 1'b1;
        w_in_data  = r_mem_l[r_rptr];
      end
      S_SEND_R: begin
        w_in_valid = 1'b1;
        w_in_eop   = 1'b1;
        w_in_data  = r_mem_r[r_rptr];
      end
      default: ;
    endcase
  end

  // Ready is forced low while reset is asserted so every output reads 0.
  assign w_out_ready = reset_n & (~(r_dst_valid & ~bus.dst_ready) | ~r_lpres);
  assign w_take      = bus.cic_out_valid & w_out_ready;
  assign w_take_l    = w_take & ~bus.cic_out_channel;
  assign w_load      = w_take & bus.cic_out_channel & r_lpres;
  assign w_set_ch    = (w_take_l & r_lpres) | (w_take & bus.cic_out_channel & ~r_lpres);
  assign w_set_ce    = w_take & (bus.cic_out_error != 2'b00);
  assign w_set_ov    = bus.src_strobe & w_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lpres     <= 1'b0;
      r_lhold     <= '0;
      r_dst_valid <= 1'b0;
      r_dst_l     <= '0;
      r_dst_r     <= '0;
      r_overrun   <= 1'b0;
      r_ch_err    <= 1'b0;
      r_cic_err   <= 1'b0;
    end else begin
      if (w_take_l) begin
        r_lhold <= bus.cic_out_data;
        r_lpres <= 1'b1;
      end else if (w_load) begin
        r_lpres <= 1'b0;
      end
      if (w_load) begin
        r_dst_l     <= r_lhold;
        r_dst_r     <= bus.cic_out_data;
        r_dst_valid <= 1'b1;
      end else if (bus.dst_ready) begin
        r_dst_valid <= 1'b0;
      end
      r_overrun <= (r_overrun & ~bus.clr_flags) | w_set_ov;
      r_ch_err  <= (r_ch_err  & ~bus.clr_flags) | w_set_ch;
      r_cic_err <= (r_cic_err & ~bus.clr_flags) | w_set_ce;
    end
  end

  assign bus.cic_in_valid  = w_in_valid;
  assign bus.cic_in_data   = w_in_data;
  assign bus.cic_in_sop    = w_in_sop;
  assign bus.cic_in_eop    = w_in_eop;
  assign bus.cic_in_error  = 2'b00;
  assign bus.cic_out_ready = w_out_ready;
  assign bus.dst_valid     = r_dst_valid;
  assign bus.dst_l         = r_dst_l;
  assign bus.dst_r         = r_dst_r;
  assign bus.overrun       = r_overrun;
  assign bus.ch_err        = r_ch_err;
  assign bus.cic_err       = r_cic_err;
endmodule
`default_nettype wire
